// File: rtl/axi_burst_sequencer.sv
// ---------------------------------------------------------------------------
// axi_addr
//   Combinational AXI next-beat address calculator.
//   Ports:
//     addr      - current beat address
//     burst     - 0 FIXED, 1 INCR, 2 WRAP (3 treated as INCR)
//     size      - log2 bytes per beat
//     len       - beats minus one (sets the WRAP window)
//     next_addr - address of the following beat, modulo 2^ADDR_WIDTH
//
// axi_burst_sequencer
//   Per-beat address sequencer for an AXI slave front end. Accepts one burst
//   command at a time and emits one beat address per downstream handshake.
//   Ports:
//     clk, rst                       - clock, asynchronous active-high reset
//     cmd_valid/cmd_ready            - command handshake
//     cmd_addr/burst/size/len/id     - burst command fields
//     beat_valid/beat_ready          - beat handshake toward the datapath
//     beat_addr/last/cnt/id          - current beat description
//     busy                           - a burst is in progress
//     cmd_err                        - one-cycle pulse: last accepted command
//                                      was illegal and was sanitised
// ---------------------------------------------------------------------------
module axi_addr #(
    parameter int   ADDR_WIDTH = 12,
    parameter logic ALIGN_ADDR = 1'b1
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [1:0]            burst,
    input  logic [2:0]            size,
    input  logic [7:0]            len,
    output logic [ADDR_WIDTH-1:0] next_addr
);
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] size_mask;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] incr_base;

    always_comb begin
        incr      = ADDR_WIDTH'(1) << size;
        size_mask = incr - ADDR_WIDTH'(1);
        // WRAP window is (len+1) beats of 2^size bytes, always a power of two
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        // Realigning folds an unaligned start back onto the beat grid
        incr_base = ALIGN_ADDR ? (addr & ~size_mask) : addr;
        case (burst)
            2'd0:    next_addr = addr;
            2'd2:    next_addr = (addr & ~wrap_mask) | ((addr + incr) & wrap_mask);
            default: next_addr = incr_base + incr;
        endcase
    end
endmodule

module axi_burst_sequencer #(
    parameter logic ALIGN_ADDR = 1'b1,
    parameter int   ADDR_WIDTH = 12,
    parameter int   DATA_WIDTH = 32,
    parameter int   ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [1:0]            cmd_burst,
    input  logic [2:0]            cmd_size,
    input  logic [7:0]            cmd_len,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    output logic                  beat_valid,
    input  logic                  beat_ready,
    output logic [ADDR_WIDTH-1:0] beat_addr,
    output logic                  beat_last,
    output logic [7:0]            beat_cnt,
    output logic [ID_WIDTH-1:0]   beat_id,
    output logic                  busy,
    output logic                  cmd_err
);
    localparam int          DATA_SIZE = $clog2(DATA_WIDTH) - 3;
    localparam logic [2:0]  MAX_SIZE  = 3'(DATA_SIZE);
    localparam logic [1:0]  B_FIXED   = 2'd0;
    localparam logic [1:0]  B_INCR    = 2'd1;
    localparam logic [1:0]  B_WRAP    = 2'd2;
    localparam logic [1:0]  B_RSVD    = 2'd3;

    typedef enum logic [0:0] {IDLE, BURST} state_t;

    typedef struct packed {
        logic       err;
        logic [1:0] burst;
        logic [2:0] size;
    } san_t;

    // Clamp illegal commands to something the datapath can execute and flag
    // that it happened; any number of faults yields the same single flag.
    function automatic san_t sanitise(input logic [ADDR_WIDTH-1:0] a,
                                      input logic [1:0]            b,
                                      input logic [2:0]            s,
                                      input logic [7:0]            l);
        san_t                  r;
        logic [ADDR_WIDTH-1:0] mask;
        r.err   = 1'b0;
        r.size  = s;
        r.burst = b;
        if (s > MAX_SIZE) begin
            r.size = MAX_SIZE;
            r.err  = 1'b1;
        end
        mask = (ADDR_WIDTH'(1) << r.size) - ADDR_WIDTH'(1);
        if (b == B_RSVD) begin
            r.burst = B_INCR;
            r.err   = 1'b1;
        end else if (b == B_WRAP) begin
            if (!(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15) ||
                ((a & mask) != '0)) begin
                r.burst = B_INCR;
                r.err   = 1'b1;
            end
        end
        return r;
    endfunction

    state_t                state;
    logic [1:0]            burst_q;
    logic [2:0]            size_q;
    logic [7:0]            len_q;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  cmd_hs;
    san_t                  san;

    axi_addr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ALIGN_ADDR (ALIGN_ADDR)
    ) u_axi_addr (
        .addr      (beat_addr),
        .burst     (burst_q),
        .size      (size_q),
        .len       (len_q),
        .next_addr (next_addr)
    );

    assign busy       = (state == BURST);
    assign beat_valid = (state == BURST);
    assign beat_last  = (state == BURST) && (beat_cnt == len_q);
    // In BURST a new command may only enter on the last-beat handshake so the
    // next burst follows without a bubble.
    assign cmd_ready  = !rst && ((state == IDLE) || (beat_ready && beat_last));
    assign cmd_hs     = cmd_valid && cmd_ready;
    assign san        = sanitise(cmd_addr, cmd_burst, cmd_size, cmd_len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            burst_q   <= B_FIXED;
            size_q    <= '0;
            len_q     <= '0;
            beat_addr <= '0;
            beat_cnt  <= '0;
            beat_id   <= '0;
            cmd_err   <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            if (cmd_hs) begin
                state     <= BURST;
                burst_q   <= san.burst;
                size_q    <= san.size;
                len_q     <= cmd_len;
                beat_addr <= cmd_addr;
                beat_cnt  <= '0;
                beat_id   <= cmd_id;
                cmd_err   <= san.err;
            end else if (state == BURST && beat_ready) begin
                if (beat_last) begin
                    state <= IDLE;
                end else begin
                    beat_addr <= next_addr;
                    beat_cnt  <= beat_cnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_burst_sequencer.sv
module tb_axi_burst_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [11:0] cmd_addr;
    logic [1:0]  cmd_burst;
    logic [2:0]  cmd_size;
    logic [7:0]  cmd_len;
    logic [3:0]  cmd_id;
    logic        beat_valid;
    logic        beat_ready;
    logic [11:0] beat_addr;
    logic        beat_last;
    logic [7:0]  beat_cnt;
    logic [3:0]  beat_id;
    logic        busy;
    logic        cmd_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi_burst_sequencer #(
        .ALIGN_ADDR (1'b1),
        .ADDR_WIDTH (12),
        .DATA_WIDTH (32),
        .ID_WIDTH   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_burst  (cmd_burst),
        .cmd_size   (cmd_size),
        .cmd_len    (cmd_len),
        .cmd_id     (cmd_id),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .beat_addr  (beat_addr),
        .beat_last  (beat_last),
        .beat_cnt   (beat_cnt),
        .beat_id    (beat_id),
        .busy       (busy),
        .cmd_err    (cmd_err)
    );

    typedef struct {
        logic        cv;
        logic [11:0] ca;
        logic [1:0]  cb;
        logic [2:0]  cs;
        logic [7:0]  cl;
        logic [3:0]  ci;
        logic        br;
        logic        ebv;
        logic [11:0] ea;
        logic        el;
        logic [7:0]  ec;
        logic [3:0]  eid;
        logic        eerr;
        logic        erdy;
    } row_t;

    row_t rows[$];

    task automatic add(input logic cv, input logic [11:0] ca, input logic [1:0] cb,
                       input logic [2:0] cs, input logic [7:0] cl, input logic [3:0] ci,
                       input logic br, input logic ebv, input logic [11:0] ea,
                       input logic el, input logic [7:0] ec, input logic [3:0] eid,
                       input logic eerr, input logic erdy);
        row_t r;
        r.cv = cv; r.ca = ca; r.cb = cb; r.cs = cs; r.cl = cl; r.ci = ci;
        r.br = br; r.ebv = ebv; r.ea = ea; r.el = el; r.ec = ec; r.eid = eid;
        r.eerr = eerr; r.erdy = erdy;
        rows.push_back(r);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s [%0d]: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive_cmd(input logic cv, input logic [11:0] ca, input logic [1:0] cb,
                             input logic [2:0] cs, input logic [7:0] cl, input logic [3:0] ci);
        cmd_valid = cv; cmd_addr = ca; cmd_burst = cb;
        cmd_size = cs; cmd_len = cl; cmd_id = ci;
    endtask

    initial begin
        int n;
        int seen;
        rst        = 1'b1;
        beat_ready = 1'b1;
        drive_cmd(0, 0, 0, 0, 0, 0);

        // INCR 0x004 size 2 len 3
        add(1,'h004,1,2,3,1, 1, 0,'h000,0,0,0, 0,1);
        add(0,0,0,0,0,0,     1, 1,'h004,0,0,1, 0,0);
        add(0,0,0,0,0,0,     1, 1,'h008,0,1,1, 0,0);
        add(0,0,0,0,0,0,     1, 1,'h00C,0,2,1, 0,0);
        add(0,0,0,0,0,0,     1, 1,'h010,1,3,1, 0,1);
        // WRAP 0x008 size 2 len 3
        add(1,'h008,2,2,3,2, 1, 0,'h000,0,0,0, 0,1);
        add(0,0,0,0,0,0,     1, 1,'h008,0,0,2, 0,0);
        add(0,0,0,0,0,0,     1, 1,'h00C,0,1,2, 0,0);
        add(0,0,0,0,0,0,     1, 1,'h000,0,2,2, 0,0);
        add(0,0,0,0,0,0,     1, 1,'h004,1,3,2, 0,1);
        // WRAP len 2 -> sanitised to INCR
        add(1,'h008,2,2,2,3, 1, 0,'h000,0,0,0, 0,1);
        add(0,0,0,0,0,0,     1, 1,'h008,0,0,3, 1,0);
        add(0,0,0,0,0,0,     1, 1,'h00C,0,1,3, 0,0);
        add(0,0,0,0,0,0,     1, 1,'h010,1,2,3, 0,1);
        // FIXED 0x020 len 2, beat_ready 1,0,0,1,1; a command waiting mid-burst is refused
        add(1,'h020,0,2,2,4, 1, 0,'h000,0,0,0, 0,1);
        add(0,0,0,0,0,0,     1, 1,'h020,0,0,4, 0,0);
        add(1,'h7F0,1,0,0,9, 0, 1,'h020,0,1,4, 0,0);
        add(1,'h7F0,1,0,0,9, 0, 1,'h020,0,1,4, 0,0);
        add(0,0,0,0,0,0,     1, 1,'h020,0,1,4, 0,0);
        add(0,0,0,0,0,0,     1, 1,'h020,1,2,4, 0,1);
        // INCR unaligned start, realigned after first beat
        add(1,'h003,1,2,2,5, 1, 0,'h000,0,0,0, 0,1);
        add(0,0,0,0,0,0,     1, 1,'h003,0,0,5, 0,0);
        add(0,0,0,0,0,0,     1, 1,'h004,0,1,5, 0,0);
        add(0,0,0,0,0,0,     1, 1,'h008,1,2,5, 0,1);
        // INCR wraps past top of address space
        add(1,'hFFC,1,2,1,6, 1, 0,'h000,0,0,0, 0,1);
        add(0,0,0,0,0,0,     1, 1,'hFFC,0,0,6, 0,0);
        add(0,0,0,0,0,0,     1, 1,'h000,1,1,6, 0,1);
        // size 3 on 32-bit bus -> clamped to stride 4
        add(1,'h010,1,3,1,7, 1, 0,'h000,0,0,0, 0,1);
        add(0,0,0,0,0,0,     1, 1,'h010,0,0,7, 1,0);
        add(0,0,0,0,0,0,     1, 1,'h014,1,1,7, 0,1);
        // Back-to-back: second command accepted on the last-beat handshake
        add(1,'h040,1,2,1,4, 1, 0,'h000,0,0,0, 0,1);
        add(0,0,0,0,0,0,     1, 1,'h040,0,0,4, 0,0);
        add(1,'h100,1,2,0,5, 1, 1,'h044,1,1,4, 0,1);
        add(0,0,0,0,0,0,     1, 1,'h100,1,0,5, 0,1);
        add(0,0,0,0,0,0,     1, 0,'h000,0,0,0, 0,1);

        // Reset state
        #12;
        check("rst_cmd_ready", 0, cmd_ready, 0);
        check("rst_beat_valid", 0, beat_valid, 0);
        check("rst_busy", 0, busy, 0);
        check("rst_beat_last", 0, beat_last, 0);
        check("rst_cmd_err", 0, cmd_err, 0);
        check("rst_beat_addr", 0, beat_addr, 0);
        check("rst_beat_cnt", 0, beat_cnt, 0);
        check("rst_beat_id", 0, beat_id, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (rows[i]) begin
            @(negedge clk);
            drive_cmd(rows[i].cv, rows[i].ca, rows[i].cb, rows[i].cs, rows[i].cl, rows[i].ci);
            beat_ready = rows[i].br;
            #2;
            check("beat_valid", i, beat_valid, rows[i].ebv);
            check("busy", i, busy, rows[i].ebv);
            check("beat_last", i, beat_last, rows[i].el);
            check("cmd_err", i, cmd_err, rows[i].eerr);
            check("cmd_ready", i, cmd_ready, rows[i].erdy);
            if (rows[i].ebv) begin
                check("beat_addr", i, beat_addr, rows[i].ea);
                check("beat_cnt", i, beat_cnt, rows[i].ec);
                check("beat_id", i, beat_id, rows[i].eid);
            end
        end

        // len 255: 256 beats, last only on index 255
        @(negedge clk);
        drive_cmd(1, 'h0AA, 0, 0, 255, 3);
        beat_ready = 1'b1;
        n    = 0;
        seen = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            drive_cmd(0, 0, 0, 0, 0, 0);
            #2;
            if (beat_valid) begin
                n++;
                if (beat_last) begin
                    seen = 1;
                    check("len255_last_cnt", n, beat_cnt, 255);
                    break;
                end
            end
        end
        check("len255_beats", 0, n, 256);
        check("len255_done", 0, seen, 1);

        // Reset during beat_cnt=1 of a len-7 burst
        @(negedge clk);
        drive_cmd(1, 'h200, 1, 2, 7, 6);
        @(negedge clk);
        drive_cmd(0, 0, 0, 0, 0, 0);
        #2;
        check("mid_cnt0", 0, beat_cnt, 0);
        @(negedge clk);
        #2;
        check("mid_cnt1", 0, beat_cnt, 1);
        check("mid_addr1", 0, beat_addr, 'h204);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 0, beat_valid, 0);
        check("mid_rst_busy", 0, busy, 0);
        check("mid_rst_ready", 0, cmd_ready, 0);
        check("mid_rst_addr", 0, beat_addr, 0);
        check("mid_rst_cnt", 0, beat_cnt, 0);
        check("mid_rst_id", 0, beat_id, 0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("post_rst_ready", 0, cmd_ready, 1);
        check("post_rst_valid", 0, beat_valid, 0);
        @(negedge clk);
        drive_cmd(1, 'h300, 1, 2, 0, 7);
        @(negedge clk);
        drive_cmd(0, 0, 0, 0, 0, 0);
        #2;
        check("new_valid", 0, beat_valid, 1);
        check("new_addr", 0, beat_addr, 'h300);
        check("new_cnt", 0, beat_cnt, 0);
        check("new_id", 0, beat_id, 7);
        check("new_last", 0, beat_last, 1);
        @(negedge clk);
        #2;
        check("new_idle", 0, beat_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
